// File: rtl/multicycle_decoder.sv
// Main control for the multicycle ARM core: Moore sequencing FSM plus combinational ALU/PC decode.
// Enables are raw requests; the conditional-execution stage gates FlagW/PCS/RegW/MemW with CondEx.
module multicycle_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_e;

  state_e state_q, state_d;
  state_e out_state;

  logic       branch;
  logic       alu_op;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic       ir_write_raw;
  logic       next_pc_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w_raw;
  logic       cmd_ok;
  logic       pcs_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Under reset the datapath selects are shown as FETCH so the first fetch sees a settled path.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    branch       = 1'b0;
    alu_op       = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    case (out_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_EXECR: begin
        alu_op = 1'b1;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB: begin
        reg_w_raw = 1'b1;
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_w_raw = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w_raw  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Unsupported data-processing commands execute as ADD but must not touch the flags.
  always_comb begin
    alu_ctl    = 2'b00;
    cmd_ok     = 1'b0;
    flag_w_raw = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin alu_ctl = 2'b00; cmd_ok = 1'b1; end
        4'b0010: begin alu_ctl = 2'b01; cmd_ok = 1'b1; end
        4'b0000: begin alu_ctl = 2'b10; cmd_ok = 1'b1; end
        4'b1100: begin alu_ctl = 2'b11; cmd_ok = 1'b1; end
        default: begin alu_ctl = 2'b00; cmd_ok = 1'b0; end
      endcase
      if (cmd_ok) begin
        flag_w_raw = {Funct[0], Funct[0] & ~alu_ctl[1]};
      end
    end
  end

  assign pcs_raw = branch | (reg_w_raw & (Rd == 4'hF));

  assign FlagW      = reset ? 2'b00 : flag_w_raw;
  assign PCS        = pcs_raw      & ~reset;
  assign NextPC     = next_pc_raw  & ~reset;
  assign RegW       = reg_w_raw    & ~reset;
  assign MemW       = mem_w_raw    & ~reset;
  assign IRWrite    = ir_write_raw & ~reset;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ALUControl = alu_ctl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign State      = state_q;

endmodule

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
- Main control unit for the multicycle ARM core: a Moore FSM plus combinational ALU and PC decode.
- Sits upstream of the conditional-execution logic and produces the raw FlagW/PCS/RegW/MemW requests that the conditional logic gates with CondEx.
- Also drives datapath mux selects and the instruction-register/PC enables for each step of fetch, decode, execute, memory and writeback.

Parameters:
- None. Fixed-function block; 4-bit state encoding is internal.

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- Op  in  2  instr[27:26], read from the instruction register
- Funct  in  6  instr[25:20]
- Rd  in  4  instr[15:12]
- FlagW  out  2  flag-write request; [1]=NZ, [0]=CV
- PCS  out  1  PC-source request: branch, or register write to R15
- NextPC  out  1  unconditional PC write (fetch increment)
- RegW  out  1  register-file write request
- MemW  out  1  data-memory write request
- IRWrite  out  1  instruction-register load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- State  out  4  current state, for debug/verification

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Codes 11–15 must never be reached; if reached, the next state is FETCH and all enables are 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN -> FETCH.
- Latencies, counted as cycles from FETCH until the next FETCH:
  - LDR: 5
  - STR: 4
  - data-processing: 4
  - branch: 3
  - undefined op: 3
- Moore outputs by state (any signal not listed is 0 / 00):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all 0.
- ALU decode:
  - If ALUOp=0: ALUControl=00 and FlagW=00.
  - If ALUOp=1, Funct[4:1] selects ALUControl: 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11; any other value -> 00 with FlagW forced to 00.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ALUControl is 00 or 01).
- PCS = Branch | (RegW & (Rd==4'hF)). It is therefore asserted only in BRANCH, or in ALUWB/MEMWB with Rd=15.
- ImmSrc and RegSrc are combinational from Op and valid in every state.
- Reset:
  - reset=1 at a posedge loads State=FETCH, regardless of the current state (including mid-instruction, e.g. MEMWR).
  - While reset=1, FlagW, PCS, NextPC, RegW, MemW and IRWrite are forced to 0 combinationally. Selects take their FETCH values.
  - After reset deasserts, the first cycle is FETCH with IRWrite=NextPC=1.
- No write enable may be asserted in two consecutive cycles, except IRWrite/NextPC in back-to-back FETCH after reset.
- Op, Funct and Rd are sampled by the FSM only in DECODE and MEMADR, and by the output decode only in EXECR/EXECI/ALUWB/MEMWB.

Test Plan:
- reset held 3 cycles while in MEMWR -> State=0, MemW=0 during reset. First cycle after release: IRWrite=1, NextPC=1, State=0.
- ADD R1,R2,R3 with S (Op=00, Funct=001001, Rd=1) -> states 0,1,6,8,0. In EXECR: ALUControl=00, FlagW=11. In ALUWB: RegW=1, PCS=0.
- ORR immediate with S, Rd=15 (Op=00, Funct=111001) -> states 0,1,7,8,0. In EXECI: ALUControl=11, FlagW=10. In ALUWB: PCS=1.
- LDR (Op=01, Funct=011001) -> states 0,1,2,3,4,0. In MEMRD: AdrSrc=1. In MEMWB: ResultSrc=01, RegW=1.
- STR (Op=01, Funct=011000) -> states 0,1,2,5,0. MemW=1 only in state 5; RegW never 1.
- B (Op=10) -> states 0,1,9,0 with PCS=1 in state 9. Op=11 -> states 0,1,10,0 with all enables 0. Unsupported Funct[4:1]=1111 -> FlagW=00.
